// File: rtl/tdm_nibble_receiver_pkg.sv
// Shared types and sizes for the 4-lane nibble link receiver.
package tdm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    COMMIT
  } state_e;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned CHAN_W    = 2;
  localparam int unsigned COUNT_W   = 8;

  // Increment that sticks at all-ones.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == '1) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/tdm_nibble_receiver_if.sv
// Beat handshake of the nibble link: lane-tagged payload with valid/ready.
interface tdm_nibble_receiver_if #(
  parameter int unsigned LANE_W = 4
);
  import tdm_pkg::*;

  logic [LANE_W-1:0] data_in;
  logic [CHAN_W-1:0] chan_in;
  logic              valid_in;
  logic              ready_out;

  modport master (output data_in, chan_in, valid_in, input ready_out);
  modport slave  (input data_in, chan_in, valid_in, output ready_out);

endinterface

// File: rtl/tdm_rx_timeout.sv
// Idle down-counter: reloads on each accepted beat, flags expiry after CYCLES idle cycles.
module tdm_rx_timeout #(
  parameter int unsigned CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic reload,
  output logic expire_c
);

  localparam int unsigned CNT_W = $clog2(CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (reload) begin
      cnt_q <= CNT_W'(CYCLES);
    end else if (active && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // An accepted beat in the same cycle wins over expiry.
  assign expire_c = active && !reload && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/tdm_nibble_receiver.sv
// Reassembles lane 0..3 nibble beats into a frame and commits it atomically to data_out.
// Optional idle timeout inside a frame: define TDM_RX_TIMEOUT_EN.
module tdm_nibble_receiver
  import tdm_pkg::*;
#(
  parameter int unsigned LANE_W         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  tdm_nibble_receiver_if.slave        rx,
  output logic [NUM_LANES*LANE_W-1:0] data_out,
  output logic                        frame_done,
  output logic                        seq_error,
  output logic [COUNT_W-1:0]          frame_count,
  output logic [COUNT_W-1:0]          error_count
);

  state_e                              state_q, state_d;
  logic [CHAN_W-1:0]                   expect_q, expect_d;
  logic [NUM_LANES-1:0][LANE_W-1:0]    shadow_q, shadow_d;
  logic [NUM_LANES*LANE_W-1:0]         data_d;
  logic                                done_d, err_d;
  logic [COUNT_W-1:0]                  fcount_d, ecount_d;
  logic                                accept;
  logic                                timeout_c;

  assign rx.ready_out = enable && (state_q != COMMIT);
  assign accept       = rx.valid_in && rx.ready_out;

`ifdef TDM_RX_TIMEOUT_EN
  tdm_rx_timeout #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .active   (state_q == COLLECT),
    .reload   (accept),
    .expire_c (timeout_c)
  );
`else
  assign timeout_c = 1'b0;
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    expect_d = expect_q;
    shadow_d = shadow_q;
    data_d   = data_out;
    done_d   = 1'b0;
    err_d    = 1'b0;
    fcount_d = frame_count;
    ecount_d = error_count;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (rx.chan_in == CHAN_W'(0)) begin
            shadow_d[0] = rx.data_in;
            expect_d    = CHAN_W'(1);
            state_d     = COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (accept) begin
          if (rx.chan_in == expect_q) begin
            shadow_d[expect_q] = rx.data_in;
            if (expect_q == CHAN_W'(NUM_LANES - 1)) begin
              state_d = COMMIT;
            end else begin
              expect_d = expect_q + CHAN_W'(1);
            end
          end else if (rx.chan_in == CHAN_W'(0)) begin
            // Lane 0 out of turn starts a fresh frame.
            err_d       = 1'b1;
            shadow_d[0] = rx.data_in;
            expect_d    = CHAN_W'(1);
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (timeout_c) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      COMMIT: begin
        data_d   = shadow_q;
        done_d   = 1'b1;
        fcount_d = frame_count + COUNT_W'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (err_d) begin
      ecount_d = sat_inc(error_count);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      expect_q    <= '0;
      shadow_q    <= '0;
      data_out    <= '0;
      frame_done  <= 1'b0;
      seq_error   <= 1'b0;
      frame_count <= '0;
      error_count <= '0;
    end else begin
      state_q     <= state_d;
      expect_q    <= expect_d;
      shadow_q    <= shadow_d;
      data_out    <= data_d;
      frame_done  <= done_d;
      seq_error   <= err_d;
      frame_count <= fcount_d;
      error_count <= ecount_d;
    end
  end

endmodule

// File: tb/tb_tdm_nibble_receiver.sv
// Self-checking bench for tdm_nibble_receiver: vector table plus scoreboard of committed frames.
module tb_tdm_nibble_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] data_out;
  logic        frame_done;
  logic        seq_error;
  logic [7:0]  frame_count;
  logic [7:0]  error_count;

  int total = 0;
  int bad   = 0;

  // Beat i uses nibble i of ch/d.
  typedef struct {
    int          n;
    logic [31:0] ch;
    logic [31:0] d;
    int          errs;
    logic [15:0] frame;
  } vec_t;

  localparam int NV = 5;
  vec_t vec[NV];

  logic [15:0] sb[$];
  logic [15:0] prev_data = '0;
  int          err_pulses = 0;
  int          done_cnt   = 0;
  int          ready_low  = 0;

  int          exp_pulses = 0;
  logic [7:0]  exp_errs   = '0;
  logic [7:0]  exp_frames = '0;
  logic [15:0] last_frame = '0;

  tdm_nibble_receiver_if #(.LANE_W(4)) bus ();

  tdm_nibble_receiver #(
    .LANE_W         (4),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .rx          (bus.slave),
    .data_out    (data_out),
    .frame_done  (frame_done),
    .seq_error   (seq_error),
    .frame_count (frame_count),
    .error_count (error_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic send_beat(input logic [1:0] ch, input logic [3:0] d);
    int tries;
    tries = 0;
    bus.chan_in  = ch;
    bus.data_in  = d;
    bus.valid_in = 1'b1;
    @(negedge clk);
    while (!bus.ready_out) begin
      tries++;
      if (tries > 20) begin
        total++;
        bad++;
        $display("FAIL beat_stall: ready_out stuck low for chan %0d", ch);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] f);
    sb.push_back(f);
    last_frame = f;
    exp_frames = exp_frames + 8'd1;
    for (int b = 0; b < 4; b++) send_beat(2'(b), 4'(f >> (4 * b)));
  endtask

  task automatic add_err(input int n);
    for (int k = 0; k < n; k++) begin
      exp_pulses++;
      if (exp_errs != 8'hFF) exp_errs = exp_errs + 8'd1;
    end
  endtask

  task automatic do_reset();
    bus.valid_in = 1'b0;
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    sb.delete();
    exp_errs   = '0;
    exp_frames = '0;
    last_frame = '0;
  endtask

  // Scoreboard: pop on every commit; data_out must hold between commits.
  always @(negedge clk) begin
    if (reset) begin
      prev_data = '0;
    end else begin
      if (frame_done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: commit of %0h with nothing expected", data_out);
        end else begin
          check("sb_frame", 32'(data_out), 32'(sb.pop_front()));
        end
      end else begin
        check("data_hold", 32'(data_out), 32'(prev_data));
      end
      prev_data = data_out;
      if (seq_error) err_pulses++;
      if (enable && !bus.ready_out) ready_low++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{4, 32'h3210,    32'hDCBA,    0, 16'hDCBA};
    vec[1] = '{6, 32'h321020,  32'h543251,  1, 16'h5432};
    vec[2] = '{6, 32'h321010,  32'hA98721,  1, 16'hA987};
    vec[3] = '{5, 32'h32103,   32'h3210F,   1, 16'h3210};
    vec[4] = '{7, 32'h3210110, 32'h7654211, 1, 16'h7654};

    reset        = 1'b1;
    enable       = 1'b1;
    bus.valid_in = 1'b0;
    bus.chan_in  = '0;
    bus.data_in  = '0;
    cycles(2);
    reset = 1'b0;
    #1;

    check("rst_data_out",    32'(data_out),    32'h0);
    check("rst_frame_done",  32'(frame_done),  32'h0);
    check("rst_seq_error",   32'(seq_error),   32'h0);
    check("rst_frame_count", 32'(frame_count), 32'h0);
    check("rst_error_count", 32'(error_count), 32'h0);
    check("rst_ready_out",   32'(bus.ready_out), 32'h1);

    // Vector table: each record ends with a lane-3 beat that commits its frame.
    for (int i = 0; i < NV; i++) begin
      sb.push_back(vec[i].frame);
      for (int b = 0; b < vec[i].n; b++)
        send_beat(2'(vec[i].ch >> (4 * b)), 4'(vec[i].d >> (4 * b)));
      bus.valid_in = 1'b0;
      add_err(vec[i].errs);
      exp_frames = exp_frames + 8'd1;
      check("commit_ready_low", 32'(bus.ready_out), 32'h0);
      check("commit_pending",   32'(frame_done),    32'h0);
      cycles(1);
      check("frame_done_pulse", 32'(frame_done),  32'h1);
      check("data_out",         32'(data_out),    32'(vec[i].frame));
      check("frame_count",      32'(frame_count), 32'(exp_frames));
      cycles(1);
      check("frame_done_end",   32'(frame_done),  32'h0);
      check("error_count",      32'(error_count), 32'(exp_errs));
      check("error_pulses",     32'(err_pulses),  32'(exp_pulses));
      if (i == 0) begin
        check("ready_low_cycles", 32'(ready_low), 32'd1);
        check("done_pulses",      32'(done_cnt),  32'd1);
      end
    end
    last_frame = vec[NV-1].frame;

    // Reset in the middle of a frame clears everything.
    send_beat(2'd0, 4'h1);
    send_beat(2'd1, 4'h2);
    do_reset();
    #1;
    check("midrst_data_out",    32'(data_out),    32'h0);
    check("midrst_frame_count", 32'(frame_count), 32'h0);
    check("midrst_error_count", 32'(error_count), 32'h0);
    send_frame(16'hBA98);
    bus.valid_in = 1'b0;
    cycles(2);
    check("postrst_data_out",    32'(data_out),    32'hBA98);
    check("postrst_frame_count", 32'(frame_count), 32'h1);

    // Dropping enable mid-frame abandons it; lane 2 then arrives out of order in IDLE.
    do_reset();
    send_beat(2'd0, 4'h1);
    send_beat(2'd1, 4'h2);
    bus.valid_in = 1'b0;
    enable = 1'b0;
    #1;
    check("enable_low_ready", 32'(bus.ready_out), 32'h0);
    cycles(1);
    enable = 1'b1;
    send_beat(2'd2, 4'h3);
    add_err(1);
    send_frame(16'hFEDC);
    bus.valid_in = 1'b0;
    cycles(2);
    check("enable_error_count", 32'(error_count), 32'(exp_errs));
    check("enable_data_out",    32'(data_out),    32'hFEDC);

    // 256 back-to-back frames wrap frame_count to zero.
    do_reset();
    for (int k = 0; k < 256; k++) send_frame(16'($urandom));
    bus.valid_in = 1'b0;
    cycles(3);
    check("wrap_frame_count", 32'(frame_count), 32'h0);
    check("wrap_data_out",    32'(data_out),    32'(last_frame));
    check("wrap_sb_empty",    32'(sb.size()),   32'h0);

    // 300 stray lane-1 beats saturate error_count.
    do_reset();
    for (int k = 0; k < 300; k++) send_beat(2'd1, 4'(k));
    bus.valid_in = 1'b0;
    add_err(300);
    cycles(2);
    check("sat_error_count", 32'(error_count), 32'hFF);
    check("sat_pulses",      32'(err_pulses),  32'(exp_pulses));
    check("sat_frame_count", 32'(frame_count), 32'h0);

    do_reset();
`ifdef TDM_RX_TIMEOUT_EN
    send_beat(2'd0, 4'h1);
    bus.valid_in = 1'b0;
    cycles(9);
    check("to_not_yet", 32'(seq_error), 32'h0);
    cycles(1);
    check("to_expire", 32'(seq_error), 32'h1);
    add_err(1);
    cycles(1);
    check("to_pulse_end",   32'(seq_error),   32'h0);
    check("to_error_count", 32'(error_count), 32'(exp_errs));
    send_beat(2'd1, 4'h2);
    bus.valid_in = 1'b0;
    add_err(1);
    cycles(2);
    check("to_back_in_idle", 32'(error_count), 32'(exp_errs));
`else
    send_beat(2'd0, 4'h1);
    bus.valid_in = 1'b0;
    cycles(1000);
    check("no_to_pulses", 32'(err_pulses), 32'(exp_pulses));
    check("no_to_count",  32'(error_count), 32'h0);
    sb.push_back(16'h4321);
    send_beat(2'd1, 4'h2);
    send_beat(2'd2, 4'h3);
    send_beat(2'd3, 4'h4);
    bus.valid_in = 1'b0;
    cycles(2);
    check("no_to_commit",      32'(data_out),    32'h4321);
    check("no_to_frame_count", 32'(frame_count), 32'h1);
`endif

    check("final_sb_empty", 32'(sb.size()),  32'h0);
    check("final_pulses",   32'(err_pulses), 32'(exp_pulses));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdm_nibble_receiver.md
# tdm_nibble_receiver

Receive end of the board's 4-lane nibble link: accepts time-multiplexed 4-bit beats tagged with a 2-bit lane number over a valid/ready handshake. It reassembles one beat per lane, in order, into a shadow register and commits the full frame atomically to a 16-bit output that drives the LED bank. It is the sequential counterpart of the switch-side 4:1 lane multiplexer and replaces the combinational demultiplexer on the LED side.

## Interface
- LANE_W, 4, data bits per beat; the output is 4*LANE_W wide.
- TIMEOUT_CYCLES, 255, idle cycles allowed between beats inside a frame. Used only with the timeout feature compiled in.

- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; one clock, synchronous reset for the whole block.
- enable  in  1  block enable (centre button); low forces resync.
- data_in  in  LANE_W  beat payload.
- chan_in  in  2  lane tag of the beat, 0..3.
- valid_in  in  1  beat present.
- ready_out  out  1  combinational: enable && state != COMMIT.
- data_out  out  4*LANE_W  committed frame; lane k at bits [k*LANE_W +: LANE_W]; reset 0.
- frame_done  out  1  one-cycle pulse per committed frame; reset 0.
- seq_error  out  1  one-cycle pulse per sequence or timeout error; reset 0.
- frame_count  out  8  committed frames, wraps 255→0; reset 0.
- error_count  out  8  errors, saturates at 255; reset 0.

## Operation
- Beat is accepted at a rising edge where valid_in && ready_out; no other beat has any effect.
- States: IDLE (expect lane 0), COLLECT (expect lane k, 1..3), COMMIT (one cycle).
- IDLE:
  - Accepted chan 0 → store to shadow[0], expect 1, go to COLLECT.
  - Accepted chan ≠ 0 → error, stay in IDLE, discard the beat.
- COLLECT, expecting k:
  - chan == k, k < 3 → store, expect k+1.
  - chan == 3 == k → store, go to COMMIT.
  - chan == 0 → error, restart the frame: store as shadow[0], expect 1.
  - Any other chan → error, go to IDLE, discard the beat.
- COMMIT: data_out ← shadow, frame_done pulse, frame_count++, go to IDLE. Commit always completes, even if enable drops.
- Error: seq_error pulse; error_count++ unless already 255. A partial frame never reaches data_out.
- enable low in IDLE or COLLECT: go to IDLE and drop partial progress. data_out and the counters hold.
- reset at any point, including mid-frame or in COMMIT: all state and outputs return to reset values. The shadow register clears to 0.

## Timing
- Chan 3 beat accepted at edge N → in COMMIT during cycle N..N+1, with ready_out low.
- At edge N+1: data_out updates and frame_done/frame_count assert. frame_done deasserts at edge N+2.
- seq_error asserts at the edge that accepts the offending beat, or at the edge that detects the timeout. It lasts one cycle.
- Back-to-back frames with valid_in held high: minimum 5 cycles per frame (4 beats + COMMIT bubble).
- Simultaneous timeout expiry and accepted beat: the beat wins and the counter reloads.

## Configuration
- TDM_RX_TIMEOUT_EN defined:
  - In COLLECT, an idle counter reloads on every accepted beat.
  - After TIMEOUT_CYCLES consecutive cycles without an accepted beat: error pulse, error_count++, go to IDLE.
  - The counter is inactive in IDLE and COMMIT.
- TDM_RX_TIMEOUT_EN undefined: no counter and no timeout. COLLECT waits indefinitely. TIMEOUT_CYCLES is ignored.

## Structure
- Package tdm_pkg holds:
  - State enum {IDLE, COLLECT, COMMIT}.
  - NUM_LANES = 4 and CHAN_W = 2.
  - COUNT_W = 8 for frame_count and error_count.
- One sub-module, tdm_rx_timeout (reload/expire down-counter), instantiated only under TDM_RX_TIMEOUT_EN.

## Test plan
- Beats 0:A, 1:B, 2:C, 3:D on consecutive cycles, valid held → data_out = 0xDCBA one cycle after the chan 3 beat. frame_done is a single pulse, frame_count = 1, ready_out is low for exactly one cycle.
- Beats 0:1, 2:5 → seq_error pulse and error_count = 1. Following beats 0:2, 1:3, 2:4, 3:5 commit 0x5432. data_out is unchanged until that commit.
- Beats 0:1, 1:2, then 0:7, 1:8, 2:9, 3:A → one error. The commit is 0xA987 (restarted frame).
- Assert reset after 2 accepted beats → all outputs 0. The next 0..3 frame commits normally with frame_count = 1.
- 256 good frames → frame_count = 0. 300 lane-1 beats issued in IDLE → error_count = 255, saturated.
- With TDM_RX_TIMEOUT_EN and TIMEOUT_CYCLES = 10: beat 0 then 10 idle cycles → seq_error and return to IDLE. Without the macro: 1000 idle cycles give no error, and beats 1..3 then commit.
